stage_e: RTL

- Execute stage of the combined ARM/RISC-V pipeline.
- Holds the D→E pipeline register and applies operand forwarding.
- Contains the ALU, the ARM NZCV flags register and condition check, and branch resolution.
- Consumes all decode-stage outputs and produces the M-stage inputs plus the redirect (PCSrcE/PCTargetE) to fetch.

---
 rtl/stage_e.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/stage_e.sv
// -----------------------------------------------------------------------------
// stage_e : execute stage of the combined ARM / RISC-V pipeline.
//
// Holds the D->E pipeline register, selects forwarded operands, runs the
// 32-bit ALU, keeps the ARM NZCV flags register and evaluates the ARM
// condition field, and resolves branches (PCSrcE / PCTargetE) for fetch.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   arm             1 = ARM mode, 0 = RISC-V mode (static while running)
//   *D inputs       decode-stage data, indices and controls
//   ForwardAE/BE    operand selects: 00 reg, 01 ResultW, 10 ALUResultM, 11 reg
//   ALUResultM,
//   ResultW         forwarding sources
//   FlushE          synchronous bubble insert into the E register
//   *E outputs      M-stage inputs plus the fetch redirect
// -----------------------------------------------------------------------------
module stage_e (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic [31:0] Rd1D,
    input  logic [31:0] Rd2D,
    input  logic [31:0] immextD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [4:0]  RdD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        BranchD,
    input  logic        ALUSrcD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [2:0]  ALUControlD,
    input  logic [1:0]  FlagWriteD,
    input  logic [3:0]  CondD,
    input  logic [1:0]  ResultSrcD,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic [31:0] ALUResultE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCTargetE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        PCSrcE,
    output logic [1:0]  ResultSrcE
);

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        pc_src;
        logic        jump;
        logic [2:0]  alu_ctl;
        logic [1:0]  flag_write;
        logic [3:0]  cond;
        logic [1:0]  result_src;
    } e_regs_t;

    e_regs_t     r_e;
    e_regs_t     w_d;
    logic [3:0]  r_nzcv;        // {N, Z, C, V}

    logic [31:0] w_src_a;
    logic [31:0] w_write_data;
    logic [31:0] w_src_b;
    logic [31:0] w_b_op;
    logic [32:0] w_sum;
    logic        w_is_sub;
    logic        w_is_addsub;
    logic [31:0] w_result;
    logic        w_alu_n;
    logic        w_alu_z;
    logic        w_alu_c;
    logic        w_alu_v;
    logic        w_cond_ex;

    assign w_d = '{rd1: Rd1D, rd2: Rd2D, imm: immextD, pc: PCD, pc_plus4: PCPlus4D,
                   rd: RdD, rs1: Rs1D, rs2: Rs2D,
                   reg_write: RegWriteD, mem_write: MemWriteD, branch: BranchD,
                   alu_src: ALUSrcD, pc_src: PCSrcD, jump: JumpD,
                   alu_ctl: ALUControlD, flag_write: FlagWriteD, cond: CondD,
                   result_src: ResultSrcD};

    // Pipeline register and flags. The flag update is driven by the
    // instruction already in E, so it still happens on a flushing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e    <= '0;
            r_nzcv <= 4'b0000;
        end else begin
            if (arm && w_cond_ex) begin
                if (r_e.flag_write[1]) r_nzcv[3:2] <= {w_alu_n, w_alu_z};
                if (r_e.flag_write[0]) r_nzcv[1:0] <= {w_alu_c, w_alu_v};
            end
            if (FlushE) r_e <= '0;
            else        r_e <= w_d;
        end
    end

    // Operand forwarding; select 11 falls back to the register value.
    always_comb begin
        case (ForwardAE)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = ALUResultM;
            default: w_src_a = r_e.rd1;
        endcase
        case (ForwardBE)
            2'b01:   w_write_data = ResultW;
            2'b10:   w_write_data = ALUResultM;
            default: w_write_data = r_e.rd2;
        endcase
    end

    assign w_src_b = r_e.alu_src ? r_e.imm : w_write_data;

    // Shared adder: subtraction is A + ~B + 1, so carry-out is not-borrow.
    assign w_is_sub    = (r_e.alu_ctl == 3'b001);
    assign w_is_addsub = (r_e.alu_ctl == 3'b000) || w_is_sub;
    assign w_b_op      = w_is_sub ? ~w_src_b : w_src_b;
    assign w_sum       = {1'b0, w_src_a} + {1'b0, w_b_op} + {32'd0, w_is_sub};

    always_comb begin
        case (r_e.alu_ctl)
            3'b000, 3'b001: w_result = w_sum[31:0];
            3'b010:         w_result = w_src_a & w_src_b;
            3'b011:         w_result = w_src_a | w_src_b;
            3'b100:         w_result = w_src_a ^ w_src_b;
            3'b101:         w_result = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
            3'b110:         w_result = {31'd0, w_src_a < w_src_b};
            default:        w_result = 32'd0;
        endcase
    end

    assign w_alu_n = w_result[31];
    assign w_alu_z = (w_result == 32'd0);
    assign w_alu_c = w_is_addsub & w_sum[32];
    // Overflow: both adder inputs share a sign that the result lacks.
    assign w_alu_v = w_is_addsub & (w_src_a[31] == w_b_op[31]) & (w_result[31] != w_src_a[31]);

    // ARM condition evaluation against the registered flags.
    always_comb begin
        w_cond_ex = 1'b1;
        if (arm) begin
            case (r_e.cond)
                4'b0000: w_cond_ex = r_nzcv[2];
                4'b0001: w_cond_ex = ~r_nzcv[2];
                4'b0010: w_cond_ex = r_nzcv[1];
                4'b0011: w_cond_ex = ~r_nzcv[1];
                4'b0100: w_cond_ex = r_nzcv[3];
                4'b0101: w_cond_ex = ~r_nzcv[3];
                4'b0110: w_cond_ex = r_nzcv[0];
                4'b0111: w_cond_ex = ~r_nzcv[0];
                4'b1000: w_cond_ex = r_nzcv[1] & ~r_nzcv[2];
                4'b1001: w_cond_ex = ~r_nzcv[1] | r_nzcv[2];
                4'b1010: w_cond_ex = (r_nzcv[3] == r_nzcv[0]);
                4'b1011: w_cond_ex = (r_nzcv[3] != r_nzcv[0]);
                4'b1100: w_cond_ex = ~r_nzcv[2] & (r_nzcv[3] == r_nzcv[0]);
                4'b1101: w_cond_ex = r_nzcv[2] | (r_nzcv[3] != r_nzcv[0]);
                4'b1110: w_cond_ex = 1'b1;
                default: w_cond_ex = 1'b0;
            endcase
        end
    end

    assign ALUResultE = w_result;
    assign WriteDataE = w_write_data;
    assign PCPlus4E   = r_e.pc_plus4;
    assign RdE        = r_e.rd;
    assign Rs1E       = r_e.rs1;
    assign Rs2E       = r_e.rs2;
    assign ResultSrcE = r_e.result_src;
    assign RegWriteE  = r_e.reg_write & w_cond_ex;
    assign MemWriteE  = r_e.mem_write & w_cond_ex;
    assign PCSrcE     = arm ? (r_e.pc_src & w_cond_ex)
                            : (r_e.jump | (r_e.branch & w_alu_z));
    assign PCTargetE  = arm ? w_result : (r_e.pc + r_e.imm);

endmodule
